// File: rtl/lsu_bus_ctrl_if.sv
// Word-wide data-memory bus between the load/store unit and memory.
// Master drives the request side, slave returns ready/rvalid/rdata.
interface lsu_bus_ctrl_if #(
   parameter int DATA_WIDTH = 32
) ();
   logic                    bus_valid;
   logic                    bus_ready;
   logic                    bus_we;
   logic [DATA_WIDTH-1:0]   bus_addr;
   logic [DATA_WIDTH/8-1:0] bus_wstrb;
   logic [DATA_WIDTH-1:0]   bus_wdata;
   logic                    bus_rvalid;
   logic [DATA_WIDTH-1:0]   bus_rdata;
   logic                    bus_err;

   modport master (
      output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata, bus_err,
      input  bus_ready, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata, bus_err,
      output bus_ready, bus_rvalid, bus_rdata
   );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit: AddrMode access code -> valid/ready word bus transaction.
// Optional LSU_TIMEOUT_EN aborts a stuck bus access after TIMEOUT_CYCLES.
module lsu_bus_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [3:0]            AddrMode,
   input  logic [DATA_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  stall,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  misalign_err,
   lsu_bus_ctrl_if.master        bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_FIN, S_ERR
   } state_t;

   state_t      r_state, w_next;
   logic [2:0]  r_mode;
   logic [31:0] r_addr, r_wdata, r_rdata;
   logic        r_to;
   logic        w_accept, w_mis, w_store, w_hs, w_tmo;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext, w_wdata;
   logic [3:0]  w_wstrb;

   assign w_accept = req_valid & ~AddrMode[3];
   assign w_store  = (r_mode >= 3'd5);
   assign w_hs     = bus.bus_valid & bus.bus_ready;

   always_comb begin
      w_mis = 1'b0;
      unique case (AddrMode[2:0])
         3'd1, 3'd4, 3'd6: w_mis = addr[0];
         3'd2, 3'd7:       w_mis = |addr[1:0];
         default:          w_mis = 1'b0;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   logic [31:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         r_cnt <= '0;
      else if (r_state == S_REQ || r_state == S_WAIT)
         r_cnt <= r_cnt + 32'd1;
      else
         r_cnt <= '0;
   end

   assign w_tmo = (r_state == S_REQ || r_state == S_WAIT) &&
                  (r_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
   // no timeout build: the limit is irrelevant and never fires
   assign w_tmo = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      w_byte = 8'h00;
      unique case (r_addr[1:0])
         2'd0: w_byte = bus.bus_rdata[7:0];
         2'd1: w_byte = bus.bus_rdata[15:8];
         2'd2: w_byte = bus.bus_rdata[23:16];
         2'd3: w_byte = bus.bus_rdata[31:24];
         default: w_byte = 8'h00;
      endcase
      w_half = r_addr[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
      w_ext  = bus.bus_rdata;
      unique case (r_mode)
         3'd0: w_ext = {{24{w_byte[7]}}, w_byte};
         3'd1: w_ext = {{16{w_half[15]}}, w_half};
         3'd3: w_ext = {24'h0, w_byte};
         3'd4: w_ext = {16'h0, w_half};
         default: w_ext = bus.bus_rdata;
      endcase
   end

   always_comb begin
      w_wstrb = 4'b0000;
      w_wdata = 32'h0;
      unique case (r_mode)
         3'd5: begin
            w_wstrb = 4'b0001 << r_addr[1:0];
            w_wdata = {4{r_wdata[7:0]}};
         end
         3'd6: begin
            w_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{r_wdata[15:0]}};
         end
         3'd7: begin
            w_wstrb = 4'b1111;
            w_wdata = r_wdata;
         end
         default: begin
            w_wstrb = 4'b0000;
            w_wdata = 32'h0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_accept) w_next = w_mis ? S_ERR : S_REQ;
         S_REQ: begin
            if (w_hs)       w_next = w_store ? S_FIN : S_WAIT;
            else if (w_tmo) w_next = S_ERR;
         end
         S_WAIT: begin
            if (bus.bus_rvalid) w_next = S_FIN;
            else if (w_tmo)     w_next = S_ERR;
         end
         S_FIN:   w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode  <= 3'd0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_to    <= 1'b0;
      end else begin
         if (r_state == S_IDLE) begin
            r_to <= 1'b0;
            if (w_accept) begin
               r_mode  <= AddrMode[2:0];
               r_addr  <= addr;
               r_wdata <= wdata;
               r_rdata <= '0;
            end
         end else if (w_tmo) begin
            r_to <= 1'b1;
         end
         if (r_state == S_WAIT && bus.bus_rvalid)
            r_rdata <= w_ext;
      end
   end

   always_comb begin
      stall         = 1'b0;
      done          = 1'b0;
      rdata         = '0;
      misalign_err  = 1'b0;
      bus.bus_valid = 1'b0;
      bus.bus_we    = 1'b0;
      bus.bus_addr  = '0;
      bus.bus_wstrb = '0;
      bus.bus_wdata = '0;
      bus.bus_err   = 1'b0;
      unique case (r_state)
         S_IDLE: stall = w_accept;
         S_REQ: begin
            stall         = 1'b1;
            bus.bus_valid = 1'b1;
            bus.bus_we    = w_store;
            bus.bus_addr  = {r_addr[31:2], 2'b00};
            bus.bus_wstrb = w_wstrb;
            bus.bus_wdata = w_wdata;
         end
         S_WAIT: stall = 1'b1;
         S_FIN: begin
            done  = 1'b1;
            rdata = r_rdata;
         end
         S_ERR: begin
            done         = 1'b1;
            misalign_err = ~r_to;
            bus.bus_err  = r_to;
         end
         default: stall = 1'b0;
      endcase
   end
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl with a load-result scoreboard.
// Define LSU_TIMEOUT_EN to also cover the bus timeout abort.
module tb_lsu_bus_ctrl;
`ifdef LSU_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 255;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [3:0]  AddrMode;
   logic [31:0] addr, wdata, rdata;
   logic        stall, done, misalign_err;
   int          n_assert = 0;
   int          n_fail = 0;
   logic [31:0] sb[$];

   lsu_bus_ctrl_if #(.DATA_WIDTH(32)) bus ();

   lsu_bus_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .AddrMode(AddrMode),
      .addr(addr), .wdata(wdata), .stall(stall), .done(done),
      .rdata(rdata), .misalign_err(misalign_err), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_outs(input string tag);
      chk({tag, "/stall"}, stall, 0);
      chk({tag, "/done"}, done, 0);
      chk({tag, "/valid"}, bus.bus_valid, 0);
   endtask

   task automatic access(
      input string tag, input logic [3:0] m,
      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
      input int rdy_dly, input int rv_dly,
      input logic [3:0] e_strb, input logic [31:0] e_bwd,
      input logic e_load, input logic [31:0] e_rd, input int e_lat,
      input logic e_mis, input logic e_berr, input int e_vcnt);
      int  vseen;
      int  wcnt;
      bit  hs;
      bit  fin;
      logic [31:0] exp_rd;
      cyc();
      req_valid = 1'b1;
      AddrMode  = m;
      addr      = a;
      wdata     = wd;
      bus.bus_ready  = 1'b0;
      bus.bus_rvalid = 1'b0;
      if (e_load || e_mis || e_berr) sb.push_back(e_rd);
      #2;
      chk({tag, "/stall_acc"}, stall, 1);
      vseen = 0;
      wcnt  = 0;
      hs    = 0;
      fin   = 0;
      for (int n = 1; n <= 60 && !fin; n++) begin
         cyc();
         req_valid = 1'($urandom_range(0, 1));
         AddrMode  = 4'($urandom_range(0, 15));
         addr      = $urandom;
         wdata     = $urandom;
         bus.bus_ready  = !hs && (vseen >= rdy_dly);
         bus.bus_rvalid = hs && (wcnt >= rv_dly);
         bus.bus_rdata  = bus.bus_rvalid ? brd : 32'hDEADBEEF;
         #2;
         if (done) begin
            fin = 1;
            chk({tag, "/latency"}, n, e_lat);
            chk({tag, "/stall_fin"}, stall, 0);
            chk({tag, "/valid_fin"}, bus.bus_valid, 0);
            chk({tag, "/misalign"}, misalign_err, e_mis);
            chk({tag, "/bus_err"}, bus.bus_err, e_berr);
            if (e_load || e_mis || e_berr) begin
               exp_rd = (sb.size() > 0) ? sb.pop_front() : 32'hXXXXXXXX;
               chk({tag, "/rdata"}, rdata, exp_rd);
            end
         end else begin
            chk({tag, "/stall_busy"}, stall, 1);
            if (bus.bus_valid) begin
               vseen++;
               chk({tag, "/addr"}, bus.bus_addr, {a[31:2], 2'b00});
               chk({tag, "/we"}, bus.bus_we, !e_load);
               chk({tag, "/wstrb"}, bus.bus_wstrb, e_strb);
               if (!e_load) chk({tag, "/wdata"}, bus.bus_wdata, e_bwd);
               if (bus.bus_ready) hs = 1;
            end else if (hs && !bus.bus_rvalid) begin
               wcnt++;
            end
         end
      end
      chk({tag, "/completed"}, fin, 1);
      chk({tag, "/valid_cycles"}, vseen, e_vcnt);
      cyc();
      req_valid      = 1'b0;
      AddrMode       = 4'b1000;
      bus.bus_ready  = 1'b0;
      bus.bus_rvalid = 1'b0;
      #2;
      idle_outs({tag, "/after"});
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0;
      AddrMode = 4'b1000;
      addr = '0;
      wdata = '0;
      bus.bus_ready = 1'b0;
      bus.bus_rvalid = 1'b0;
      bus.bus_rdata = '0;
      cyc();
      cyc();
      #2;
      idle_outs("reset");
      chk("reset/rdata", rdata, 0);
      chk("reset/mis", misalign_err, 0);
      chk("reset/addr", bus.bus_addr, 0);
      chk("reset/strb", bus.bus_wstrb, 0);
      chk("reset/bwdata", bus.bus_wdata, 0);
      chk("reset/we", bus.bus_we, 0);
      chk("reset/err", bus.bus_err, 0);
      cyc();
      rst = 1'b0;

      access("sb", 4'b0101, 32'h1003, 32'hAABBCCDD, 0, 0, 0,
             4'b1000, 32'hDDDDDDDD, 0, 0, 2, 0, 0, 1);
      access("sh", 4'b0110, 32'h6002, 32'h1234ABCD, 0, 0, 0,
             4'b1100, 32'hABCDABCD, 0, 0, 2, 0, 0, 1);
      access("sw", 4'b0111, 32'h7000, 32'hCAFEF00D, 0, 0, 0,
             4'b1111, 32'hCAFEF00D, 0, 0, 2, 0, 0, 1);
      access("lb", 4'b0000, 32'h2001, 0, 32'h0000F280, 0, 0,
             4'b0000, 0, 1, 32'hFFFFFFF2, 3, 0, 0, 1);
      access("lbu", 4'b0011, 32'h2001, 0, 32'h0000F280, 0, 0,
             4'b0000, 0, 1, 32'h000000F2, 3, 0, 0, 1);
      access("lb_pos", 4'b0000, 32'h2003, 0, 32'h7F000000, 0, 0,
             4'b0000, 0, 1, 32'h0000007F, 3, 0, 0, 1);
      access("lh", 4'b0001, 32'h3002, 0, 32'h80011234, 0, 0,
             4'b0000, 0, 1, 32'hFFFF8001, 3, 0, 0, 1);
      access("lhu", 4'b0100, 32'h3002, 0, 32'h80011234, 0, 0,
             4'b0000, 0, 1, 32'h00008001, 3, 0, 0, 1);
      access("sw_mis", 4'b0111, 32'h4002, 32'h11111111, 0, 0, 0,
             4'b0000, 0, 0, 0, 1, 1, 0, 0);
      access("lh_mis", 4'b0001, 32'h4001, 0, 0, 0, 0,
             4'b0000, 0, 1, 0, 1, 1, 0, 0);
      access("lw_slow", 4'b0010, 32'h5000, 0, 32'h12345678, 5, 2,
             4'b0000, 0, 1, 32'h12345678, 10, 0, 0, 6);

      // no-op access codes never stall or touch the bus
      cyc();
      req_valid = 1'b1;
      AddrMode  = 4'b1000;
      addr      = 32'h8000;
      #2;
      idle_outs("none8");
      cyc();
      AddrMode = 4'b1111;
      #2;
      idle_outs("none15");
      cyc();
      req_valid = 1'b0;
      #2;
      idle_outs("none_next");

      // reset while a load waits for read data
      cyc();
      req_valid = 1'b1;
      AddrMode  = 4'b0010;
      addr      = 32'h9000;
      cyc();
      req_valid     = 1'b0;
      bus.bus_ready = 1'b1;
      #2;
      chk("rstw/valid_req", bus.bus_valid, 1);
      cyc();
      bus.bus_ready = 1'b0;
      rst = 1'b1;
      #2;
      chk("rstw/stall_wait", stall, 1);
      cyc();
      #2;
      idle_outs("rstw/in_rst");
      chk("rstw/rdata", rdata, 0);
      chk("rstw/addr", bus.bus_addr, 0);
      cyc();
      rst = 1'b0;
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = 32'hA5A5A5A5;
      #2;
      idle_outs("rstw/late_rv");
      cyc();
      bus.bus_rvalid = 1'b0;
      #2;
      idle_outs("rstw/late_rv2");

`ifdef LSU_TIMEOUT_EN
      access("tmo", 4'b0010, 32'hA000, 0, 0, 1000, 0,
             4'b0000, 0, 1, 0, TMO + 1, 0, 1, TMO);
      access("post_tmo", 4'b0111, 32'hB000, 32'h01020304, 0, 0, 0,
             4'b1111, 32'h01020304, 0, 0, 2, 0, 0, 1);
`endif

      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Load/store unit that consumes the 4-bit AddrMode access code driven by the control unit. It sits between the execute stage (ALU address out, rd2 write data) and a word-wide data-memory bus.
- Turns each access code into a valid/ready bus transaction with byte strobes, stalls the core while the access is in flight, and returns load data sign- or zero-extended for the ResultSrc mux.

Parameters:
DATA_WIDTH, 32, datapath/bus width (fixed at 32; byte lanes assume 4)
TIMEOUT_CYCLES, 255, bus wait limit; used only with LSU_TIMEOUT_EN

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  execute stage presents an access this cycle
AddrMode  in  4  0000 LB, 0001 LH, 0010 LW, 0011 LBU, 0100 LHU, 0101 SB, 0110 SH, 0111 SW, 1000 none; 1001-1111 treated as none
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rd2)
stall  out  1  hold PC/pipeline
done  out  1  one-cycle completion pulse
rdata  out  32  extended load result, valid while done=1
misalign_err  out  1  one-cycle pulse, access rejected
bus_valid  out  1  request valid
bus_ready  in  1  request accepted
bus_we  out  1  1 = write
bus_addr  out  32  {addr[31:2],2'b00}
bus_wstrb  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_rvalid  in  1  read data valid
bus_rdata  in  32  read data
bus_err  out  1  one-cycle pulse, timeout abort

Behaviour:
- Reset: state IDLE. All outputs 0: stall, done, rdata, misalign_err, bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata, bus_err.
- States: IDLE, REQ, WAIT, FIN, ERR.
- Accept condition: req_valid=1 and AddrMode in 0000-0111.
- IDLE:
  - On accept, capture AddrMode, addr and wdata into registers.
  - Aligned access -> REQ. Misaligned access -> ERR.
  - Misaligned means: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00. Byte accesses are never misaligned.
  - stall is driven combinationally to 1 in the accepting cycle.
  - No accept: stay in IDLE, stall=0.
- REQ:
  - bus_valid=1, stall=1. bus_addr, bus_we, bus_wstrb, bus_wdata are held stable until the handshake.
  - On bus_valid & bus_ready: a store goes to FIN; a load goes to WAIT.
- WAIT:
  - stall=1.
  - On bus_rvalid, capture the extracted value into rdata and go to FIN.
  - bus_rvalid outside WAIT is ignored.
- FIN: done=1, stall=0, then IDLE. Minimum latency: store 2 cycles, load 3 cycles, when ready/rvalid are immediate.
- ERR: misalign_err=1, done=1, stall=0, no bus activity, rdata=0, then IDLE.
- Store lanes:
  - SB: wstrb = 4'b0001 << addr[1:0]; bus_wdata = {4{wdata[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011; bus_wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111; bus_wdata = wdata.
  - Loads: wstrb = 0000, bus_we=0.
- Load extract: byte = bus_rdata[8*addr[1:0] +: 8]; half = bus_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- Input changes while state != IDLE are ignored (captured registers are used).
- rst mid-operation: return to IDLE next edge and drop bus_valid. A late bus_rvalid is ignored, and done is not pulsed.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to REQ and counts in REQ/WAIT.
  - When the count reaches TIMEOUT_CYCLES, the unit drops bus_valid, pulses bus_err and done with rdata=0, then returns to IDLE.
  - The counter is reset by rst.
- Undefined: the unit waits indefinitely and bus_err is tied 0.

Test Plan:
- SB addr=0x1003, wdata=0xAABBCCDD, bus_ready immediate -> bus_wstrb=1000, bus_wdata=0xDDDDDDDD, bus_addr=0x1000, done 2 cycles after accept, stall high 2 cycles.
- LB addr=0x2001, bus_rdata=0x0000F280 -> rdata=0xFFFFFFF2. Repeat as LBU -> rdata=0x000000F2. done 3 cycles after accept with immediate rvalid.
- LH addr=0x3002, bus_rdata=0x8001_1234 -> rdata=0xFFFF8001. LHU same input -> rdata=0x00008001.
- SW addr=0x4002 -> misalign_err and done pulse next cycle, bus_valid never asserted. LH addr=0x4001 -> same. AddrMode=1000 with req_valid=1 -> no stall, no bus activity.
- LW with bus_ready held low 5 cycles, then rvalid 2 cycles later -> bus_valid stable throughout, stall=1 throughout, done exactly once; an assertion of rst in the WAIT state returns all outputs to 0 and a later rvalid produces no done.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, bus_ready tied 0 -> bus_err and done pulse after 8 REQ cycles, rdata=0, unit accepts the next access.
